// File: rtl/video_ts_pkg.sv
// Shared constants and state encoding for the TS line buffer scanout.
package video_ts_pkg;

  localparam int unsigned LINE_AW  = 9;
  localparam int unsigned PIX_W    = 8;
  // Clocks from an accepted pix_stb to ts_pix_stb: one for the RAM, one for the output register.
  localparam int unsigned SCAN_LAT = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StInit = 2'd2
  } ts_state_e;

endpackage

// File: rtl/video_ts_linebuf.sv
// Dual-port 2-bank line buffer: port A writes, port B reads or writes.
// The bank select is the address MSB. Reads have one clock of latency.
module video_ts_linebuf
  import video_ts_pkg::*;
#(
  parameter int unsigned AddrW = LINE_AW + 1,
  parameter int unsigned DataW = PIX_W
) (
  input  logic             clk_i,
  input  logic             a_we_i,
  input  logic [AddrW-1:0] a_addr_i,
  input  logic [DataW-1:0] a_wdata_i,
  input  logic             b_en_i,
  input  logic             b_we_i,
  input  logic [AddrW-1:0] b_addr_i,
  input  logic [DataW-1:0] b_wdata_i,
  output logic [DataW-1:0] b_rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];
  logic [DataW-1:0] b_rdata_q;

  // No reset: the contents survive reset, and the owner never lets both ports hit one address.
  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
    if (b_we_i) begin
      mem_q[b_addr_i] <= b_wdata_i;
    end else if (b_en_i) begin
      b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/video_ts_line_scan.sv
// Double-buffered TS line scanout: the renderer fills one bank while the other is scanned.
// Define TS_LINE_CLEAR_EN for an init clear of both banks and clear-after-read scanout.
module video_ts_line_scan #(
  parameter int unsigned LINE_AW = video_ts_pkg::LINE_AW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               line_start,
  input  logic [LINE_AW-1:0] x_start,
  input  logic [LINE_AW-1:0] x_len,
  input  logic               pix_stb,
  input  logic [LINE_AW-1:0] ts_waddr,
  input  logic [7:0]         ts_wdata,
  input  logic               ts_we,
  output logic [7:0]         ts_pix,
  output logic               ts_opq,
  output logic               ts_pix_stb,
  output logic               bank,
  output logic               busy,
  output logic               scan_ovr
);
  import video_ts_pkg::*;

  ts_state_e            state_q, state_d;
  logic                 bank_q, bank_d;
  logic [LINE_AW-1:0]   rd_addr_q, rd_addr_d;
  logic [LINE_AW-1:0]   rem_q, rem_d;
  logic                 scan_ovr_q, scan_ovr_d;
  logic [SCAN_LAT-1:0]  vld_q, vld_d;
  logic [PIX_W-1:0]     ts_pix_q, ts_pix_d;
  logic                 ts_opq_q, ts_opq_d;
  logic                 rd_acc;
  logic                 pix_ok;

  logic                 a_we, b_en, b_we;
  logic [LINE_AW:0]     a_addr, b_addr;
  logic [PIX_W-1:0]     a_wdata, b_wdata, b_rdata;

`ifdef TS_LINE_CLEAR_EN
  logic [LINE_AW:0]     clr_addr_q;

  // Port B is busy clearing the clock after a read, so back-to-back strobes are dropped.
  assign pix_ok = ~vld_q[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_addr_q <= '0;
    end else if (rd_acc) begin
      clr_addr_q <= {~bank_q, rd_addr_q};
    end
  end
`else
  assign pix_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    rd_addr_d  = rd_addr_q;
    rem_d      = rem_q;
    scan_ovr_d = 1'b0;
    rd_acc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (line_start) begin
          bank_d    = ~bank_q;
          rd_addr_d = x_start;
          rem_d     = x_len;
          state_d   = StScan;
        end
      end
      StScan: begin
        if (line_start) begin
          bank_d     = ~bank_q;
          rd_addr_d  = x_start;
          rem_d      = x_len;
          scan_ovr_d = 1'b1;
        end else if (pix_stb && pix_ok) begin
          rd_acc    = 1'b1;
          rd_addr_d = rd_addr_q + LINE_AW'(1);
          rem_d     = rem_q - LINE_AW'(1);
          if (rem_q == '0) begin
            state_d = StIdle;
          end
        end
      end
      StInit: begin
`ifdef TS_LINE_CLEAR_EN
        // rd_addr doubles as the clear counter and wraps back to 0 on exit.
        rd_addr_d = rd_addr_q + LINE_AW'(1);
        if (&rd_addr_q) begin
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_we    = ts_we;
    a_addr  = {bank_q, ts_waddr};
    a_wdata = ts_wdata;
    b_en    = rd_acc;
    b_we    = 1'b0;
    b_addr  = {~bank_q, rd_addr_q};
    b_wdata = '0;
`ifdef TS_LINE_CLEAR_EN
    if (state_q == StInit) begin
      a_we    = 1'b1;
      a_addr  = {1'b0, rd_addr_q};
      a_wdata = '0;
      b_we    = 1'b1;
      b_addr  = {1'b1, rd_addr_q};
    end else if (vld_q[0]) begin
      b_we   = 1'b1;
      b_addr = clr_addr_q;
    end
`endif
  end

  always_comb begin
    vld_d    = {vld_q[SCAN_LAT-2:0], rd_acc};
    ts_pix_d = ts_pix_q;
    ts_opq_d = 1'b0;
    if (vld_q[SCAN_LAT-2]) begin
      ts_pix_d = b_rdata;
      ts_opq_d = (b_rdata[3:0] != 4'h0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
`ifdef TS_LINE_CLEAR_EN
      state_q <= StInit;
`else
      state_q <= StIdle;
`endif
      bank_q     <= 1'b0;
      rd_addr_q  <= '0;
      rem_q      <= '0;
      scan_ovr_q <= 1'b0;
      vld_q      <= '0;
      ts_pix_q   <= '0;
      ts_opq_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      rd_addr_q  <= rd_addr_d;
      rem_q      <= rem_d;
      scan_ovr_q <= scan_ovr_d;
      vld_q      <= vld_d;
      ts_pix_q   <= ts_pix_d;
      ts_opq_q   <= ts_opq_d;
    end
  end

  video_ts_linebuf #(
    .AddrW(LINE_AW + 1),
    .DataW(PIX_W)
  ) u_linebuf (
    .clk_i    (clk),
    .a_we_i   (a_we),
    .a_addr_i (a_addr),
    .a_wdata_i(a_wdata),
    .b_en_i   (b_en),
    .b_we_i   (b_we),
    .b_addr_i (b_addr),
    .b_wdata_i(b_wdata),
    .b_rdata_o(b_rdata)
  );

  assign ts_pix     = ts_pix_q;
  assign ts_opq     = ts_opq_q;
  assign ts_pix_stb = vld_q[SCAN_LAT-1];
  assign bank       = bank_q;
  assign busy       = (state_q != StIdle);
  assign scan_ovr   = scan_ovr_q;

endmodule

// File: tb/tb_video_ts_line_scan.sv
// Directed bench for video_ts_line_scan; follows TS_LINE_CLEAR_EN when it is defined.
`timescale 1ns/1ps
module tb_video_ts_line_scan;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       line_start = 1'b0;
  logic [8:0] x_start = '0;
  logic [8:0] x_len = '0;
  logic       pix_stb = 1'b0;
  logic [8:0] ts_waddr = '0;
  logic [7:0] ts_wdata = '0;
  logic       ts_we = 1'b0;
  logic [7:0] ts_pix;
  logic       ts_opq, ts_pix_stb, bank, busy, scan_ovr;

  video_ts_line_scan #(.LINE_AW(9)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_start(line_start),
    .x_start   (x_start),
    .x_len     (x_len),
    .pix_stb   (pix_stb),
    .ts_waddr  (ts_waddr),
    .ts_wdata  (ts_wdata),
    .ts_we     (ts_we),
    .ts_pix    (ts_pix),
    .ts_opq    (ts_opq),
    .ts_pix_stb(ts_pix_stb),
    .bank      (bank),
    .busy      (busy),
    .scan_ovr  (scan_ovr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        exp_bank = 1'b0;

  logic [7:0]  pix_q[$];
  logic        opq_q[$];
  int unsigned stb_cyc_q[$];
  int unsigned iss_cyc_q[$];
  int unsigned ovr_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (ts_pix_stb) begin
      pix_q.push_back(ts_pix);
      opq_q.push_back(ts_opq);
      stb_cyc_q.push_back(cyc);
    end
    if (scan_ovr) ovr_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time expired, bench did not finish");
    $fatal(1);
  end

  typedef struct packed {
    logic [8:0]      xs;
    logic [8:0]      xl;
    logic [3:0]      gap;
    logic            wr;
    logic [3:0][7:0] wdat;
    logic [3:0][7:0] exp;
  } vec_t;

  localparam int NV = 4;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [8:0] xs, input logic [3:0] gap, input logic wr,
                              input logic [31:0] wdat, input logic [31:0] exp);
    vec_t t;
    t.xs = xs; t.xl = 9'd3; t.gap = gap; t.wr = wr; t.wdat = wdat; t.exp = exp;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    ts_we = 1'b1; ts_waddr = a; ts_wdata = d;
    tick();
    ts_we = 1'b0;
  endtask

  task automatic flush();
    pix_q.delete(); opq_q.delete(); stb_cyc_q.delete(); iss_cyc_q.delete();
  endtask

  task automatic start_line(input logic [8:0] xs, input logic [8:0] xl, input logic with_pix);
    line_start = 1'b1; x_start = xs; x_len = xl; pix_stb = with_pix;
    tick();
    line_start = 1'b0; pix_stb = 1'b0;
    exp_bank = ~exp_bank;
  endtask

  task automatic pix(input int gap);
    iss_cyc_q.push_back(cyc);
    pix_stb = 1'b1;
    tick();
    pix_stb = 1'b0;
    if (gap > 1) tick(gap - 1);
  endtask

  initial begin
    vec_t        t;
    int unsigned nz, no;
    logic [8:0]  a;

    // Pixel order in the literals is p3,p2,p1,p0.
    vecs[0] = mk(9'd8,   4'd2, 1'b1, {8'h00, 8'h35, 8'h00, 8'h00}, {8'h00, 8'h35, 8'h00, 8'h00});
    vecs[1] = mk(9'd510, 4'd2, 1'b1, {8'h54, 8'h53, 8'h52, 8'h51}, {8'h54, 8'h53, 8'h52, 8'h51});
`ifdef TS_LINE_CLEAR_EN
    vecs[2] = mk(9'd8,   4'd2, 1'b0, 32'h0, {8'h00, 8'h00, 8'h00, 8'h00});
`else
    vecs[2] = mk(9'd8,   4'd2, 1'b0, 32'h0, {8'h00, 8'h35, 8'h00, 8'h00});
`endif
    vecs[3] = mk(9'd200, 4'd3, 1'b1, {8'h10, 8'h01, 8'hF0, 8'h0F}, {8'h10, 8'h01, 8'hF0, 8'h0F});

    tick(3);
    check("rst bank", bank, 1'b0);
    check("rst ts_pix", ts_pix, 8'h00);
    check("rst ts_opq", ts_opq, 1'b0);
    check("rst ts_pix_stb", ts_pix_stb, 1'b0);
    check("rst scan_ovr", scan_ovr, 1'b0);
`ifdef TS_LINE_CLEAR_EN
    check("rst busy", busy, 1'b1);
`else
    check("rst busy", busy, 1'b0);
`endif
    reset_n = 1'b1;
    tick();

`ifdef TS_LINE_CLEAR_EN
    tick(500);
    check("init busy", busy, 1'b1);
    for (int i = 0; i < 100 && busy; i++) tick();
    check("init done", busy, 1'b0);
    flush();
    start_line(9'd0, 9'd511, 1'b0);
    for (int i = 0; i < 512; i++) pix(2);
    tick(4);
    nz = 0; no = 0;
    foreach (pix_q[i]) begin
      if (pix_q[i] != 8'h00) nz++;
      if (opq_q[i]) no++;
    end
    check("clr scan count", pix_q.size(), 512);
    check("clr scan nonzero", nz, 0);
    check("clr scan opq", no, 0);
`endif

    for (int v = 0; v < NV; v++) begin
      t = vecs[v];
      if (t.wr) begin
        for (int i = 0; i < 4; i++) begin
          a = t.xs + 9'(i);
          wr(a, t.wdat[i]);
        end
      end
      flush();
      start_line(t.xs, t.xl, 1'b0);
      for (int i = 0; i < 4; i++) pix(int'(t.gap));
      tick(4);
      check($sformatf("v%0d count", v), pix_q.size(), 4);
      if (pix_q.size() == 4) begin
        for (int i = 0; i < 4; i++) begin
          check($sformatf("v%0d pix%0d", v, i), pix_q[i], t.exp[i]);
          check($sformatf("v%0d opq%0d", v, i), opq_q[i], t.exp[i][3:0] != 4'h0);
          check($sformatf("v%0d lat%0d", v, i), stb_cyc_q[i] - iss_cyc_q[i], 2);
        end
      end
      check($sformatf("v%0d bank", v), bank, exp_bank);
      check($sformatf("v%0d busy", v), busy, 1'b0);
    end

    // Abort: 100 of 200 pixels, then a line_start that also carries a pix_stb (dropped).
    flush();
    ovr_cnt = 0;
    start_line(9'd0, 9'd199, 1'b0);
    wr(9'd300, 8'h7C);
    for (int i = 0; i < 100; i++) pix(2);
    check("abort busy", busy, 1'b1);
    start_line(9'd300, 9'd0, 1'b1);
    check("abort scan_ovr", scan_ovr, 1'b1);
    check("abort bank", bank, exp_bank);
    pix(2);
    tick(4);
    check("abort ovr count", ovr_cnt, 1);
    check("abort stb count", pix_q.size(), 101);
    if (pix_q.size() > 0) check("abort new pix", pix_q[pix_q.size()-1], 8'h7C);
    check("abort idle", busy, 1'b0);

    // Continuous pix_stb for 32 clocks over a 16-pixel line, then a rescan of the same bank.
    for (int i = 0; i < 16; i++) wr(9'(100 + i), 8'(8'h80 + i));
    for (int pass = 0; pass < 2; pass++) begin
      flush();
      start_line(9'd100, 9'd15, 1'b0);
      pix_stb = 1'b1;
      tick(32);
      pix_stb = 1'b0;
      tick(4);
      check($sformatf("burst%0d count", pass), pix_q.size(), 16);
      if (pix_q.size() == 16) begin
        for (int i = 0; i < 16; i++) begin
`ifdef TS_LINE_CLEAR_EN
          check($sformatf("burst%0d pix%0d", pass, i), pix_q[i], pass == 0 ? 8'(8'h80 + i) : 8'h00);
          if (i > 0) check($sformatf("burst%0d gap%0d", pass, i), stb_cyc_q[i] - stb_cyc_q[i-1], 2);
`else
          check($sformatf("burst%0d pix%0d", pass, i), pix_q[i], 8'(8'h80 + i));
          if (i > 0) check($sformatf("burst%0d gap%0d", pass, i), stb_cyc_q[i] - stb_cyc_q[i-1], 1);
`endif
        end
      end
      check($sformatf("burst%0d idle", pass), busy, 1'b0);
      if (pass == 0) begin
        start_line(9'd0, 9'd0, 1'b0);
        pix(2);
        tick(4);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
